// File: rtl/branch_redirect_unit.sv
// branch_redirect_unit: resolves RV32I jumps/branches, drives fetch redirect, flush window and link write-back
module branch_redirect_unit #(
    parameter int FLUSH_CYCLES = 2,
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tick,
    input  logic            instr_valid,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    output logic [XLEN-1:0] pc_redirect,
    output logic            redirect,
    output logic            flush,
    output logic            rd_we,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] rd_wdata,
    output logic            misalign,
    output logic [XLEN-1:0] taken_count
);
    typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH} state_t;
    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [31:0] pc_redirect_q, pc_redirect_d, rd_wdata_q, rd_wdata_d, taken_count_q, taken_count_d;
    logic [4:0] rd_addr_q, rd_addr_d;
    logic redirect_q, redirect_d, flush_q, flush_d, rd_we_q, rd_we_d, misalign_q, misalign_d;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [31:0] imm_j, imm_i, imm_b, jalr_sum, target;
    logic is_jal, is_jalr, is_br, link, base, cond, taken;

    // decode the presented instruction and resolve whether it transfers control
    always_comb begin
        opcode   = instr[6:0];
        funct3   = instr[14:12];
        imm_j    = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
        imm_i    = {{20{instr[31]}}, instr[31:20]};
        imm_b    = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
        is_jal   = opcode == 7'b1101111;
        is_jalr  = opcode == 7'b1100111 && funct3 == 3'b000;
        is_br    = opcode == 7'b1100011;
        link     = is_jal | is_jalr;
        base     = funct3[2] ? (funct3[1] ? rs1_val < rs2_val : $signed(rs1_val) < $signed(rs2_val)) : rs1_val == rs2_val;
        cond     = funct3[2:1] == 2'b01 ? 1'b0 : base ^ funct3[0];
        jalr_sum = rs1_val + imm_i;
        target   = is_jal ? pc + imm_j : is_jalr ? {jalr_sum[31:1], 1'b0} : pc + imm_b;
        taken    = state_q == IDLE && tick && instr_valid && (link || (is_br && cond));
    end

    // next state: accept in IDLE, one-cycle REDIRECT, then a tick-counted FLUSH window
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pc_redirect_d = pc_redirect_q;
        rd_addr_d     = rd_addr_q;
        rd_wdata_d    = rd_wdata_q;
        taken_count_d = taken_count_q;
        redirect_d    = 1'b0;
        rd_we_d       = 1'b0;
        misalign_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (taken && target[1:0] == 2'b00) begin
                    state_d       = REDIRECT;
                    pc_redirect_d = target;
                    redirect_d    = 1'b1;
                    taken_count_d = taken_count_q + 32'd1;
                    if (link) begin
                        rd_addr_d  = instr[11:7];
                        rd_wdata_d = pc + 32'd4;
                        rd_we_d    = instr[11:7] != 5'd0;
                    end
                end else if (taken) begin
                    misalign_d = 1'b1;
                end
            end
            REDIRECT: begin
                state_d = FLUSH;
                cnt_d   = 4'(FLUSH_CYCLES);
            end
            FLUSH: begin
                if (tick) begin
                    cnt_d   = cnt_q - 4'd1;
                    state_d = cnt_q == 4'd1 ? IDLE : FLUSH;
                end
            end
            default: state_d = IDLE;
        endcase
        flush_d = state_d != IDLE;
    end

    // state and registered outputs, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            pc_redirect_q <= '0;
            redirect_q    <= 1'b0;
            flush_q       <= 1'b0;
            rd_we_q       <= 1'b0;
            rd_addr_q     <= '0;
            rd_wdata_q    <= '0;
            misalign_q    <= 1'b0;
            taken_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pc_redirect_q <= pc_redirect_d;
            redirect_q    <= redirect_d;
            flush_q       <= flush_d;
            rd_we_q       <= rd_we_d;
            rd_addr_q     <= rd_addr_d;
            rd_wdata_q    <= rd_wdata_d;
            misalign_q    <= misalign_d;
            taken_count_q <= taken_count_d;
        end
    end

    assign pc_redirect = pc_redirect_q;
    assign redirect    = redirect_q;
    assign flush       = flush_q;
    assign rd_we       = rd_we_q;
    assign rd_addr     = rd_addr_q;
    assign rd_wdata    = rd_wdata_q;
    assign misalign    = misalign_q;
    assign taken_count = taken_count_q;
endmodule

// File: tb/tb_branch_redirect_unit.sv
// tb_branch_redirect_unit: directed and random checks of branch_redirect_unit against a transaction-level model
module tb_branch_redirect_unit;
    localparam int FC = 2;
    localparam int K_JAL = 0, K_JALR = 1, K_BR = 2, K_OTHER = 3;

    logic clk = 1'b0, rst, tick, instr_valid;
    logic [31:0] instr, pc, rs1_val, rs2_val, pc_redirect, rd_wdata, taken_count;
    logic redirect, flush, rd_we, misalign;
    logic [4:0] rd_addr;

    int total = 0, bad = 0;

    logic [31:0] m_pc, m_wdata, m_cnt;
    logic [4:0] m_rd_addr;
    logic m_redirect, m_rd_we, m_mis, m_in_redir;
    int m_rem;

    branch_redirect_unit #(.FLUSH_CYCLES(FC), .XLEN(32)) dut (
        .clk(clk), .rst(rst), .tick(tick), .instr_valid(instr_valid), .instr(instr),
        .pc(pc), .rs1_val(rs1_val), .rs2_val(rs2_val), .pc_redirect(pc_redirect),
        .redirect(redirect), .flush(flush), .rd_we(rd_we), .rd_addr(rd_addr),
        .rd_wdata(rd_wdata), .misalign(misalign), .taken_count(taken_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc(input int kind, input logic [2:0] f3, input logic [4:0] rd, input int imm);
        logic [31:0] m;
        m = imm;
        case (kind)
            K_JAL:   return {m[20], m[10:1], m[11], m[19:12], rd, 7'b1101111};
            K_JALR:  return {m[11:0], 5'd1, f3, rd, 7'b1100111};
            K_BR:    return {m[12], m[10:5], 5'd2, 5'd1, f3, m[4:1], m[11], 7'b1100011};
            default: return {7'd0, 5'd2, 5'd1, f3, rd, 7'b0110011};
        endcase
    endfunction

    function automatic logic br_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) < $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a < b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic r, input logic t, input logic v, input int kind, input logic [2:0] f3,
                         input logic [4:0] rd, input int imm, input logic [31:0] p, input logic [31:0] a, input logic [31:0] b);
        logic tk;
        logic [31:0] tgt;
        m_redirect = 1'b0;
        m_rd_we = 1'b0;
        m_mis = 1'b0;
        if (r) begin
            m_in_redir = 1'b0; m_rem = 0; m_pc = 0; m_wdata = 0; m_cnt = 0; m_rd_addr = 0;
        end else if (m_in_redir) begin
            m_in_redir = 1'b0;
            m_rem = FC;
        end else if (m_rem > 0) begin
            if (t) m_rem--;
        end else if (t && v) begin
            tk = kind == K_JAL || (kind == K_JALR && f3 == 3'd0) || (kind == K_BR && br_taken(f3, a, b));
            tgt = kind == K_JALR ? (a + 32'(imm)) & 32'hFFFF_FFFE : p + 32'(imm);
            if (tk && tgt % 4 == 0) begin
                m_in_redir = 1'b1;
                m_redirect = 1'b1;
                m_pc = tgt;
                m_cnt = m_cnt + 1;
                if (kind != K_BR) begin
                    m_rd_addr = rd;
                    m_wdata = p + 4;
                    m_rd_we = rd != 0;
                end
            end else if (tk) begin
                m_mis = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        chk("pc_redirect", pc_redirect, m_pc);
        chk("redirect", 32'(redirect), 32'(m_redirect));
        chk("flush", 32'(flush), 32'(m_in_redir || m_rem > 0));
        chk("rd_we", 32'(rd_we), 32'(m_rd_we));
        chk("rd_addr", 32'(rd_addr), 32'(m_rd_addr));
        chk("rd_wdata", rd_wdata, m_wdata);
        chk("misalign", 32'(misalign), 32'(m_mis));
        chk("taken_count", taken_count, m_cnt);
    endtask

    task automatic step(input logic r, input logic t, input logic v, input int kind, input logic [2:0] f3,
                        input logic [4:0] rd, input int imm, input logic [31:0] p, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        rst = r; tick = t; instr_valid = v; instr = enc(kind, f3, rd, imm); pc = p; rs1_val = a; rs2_val = b;
        @(posedge clk);
        #1;
        model(r, t, v, kind, f3, rd, imm, p, a, b);
        check_all();
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, K_OTHER, 3'd0, 5'd0, 0, 32'h0, 32'h0, 32'h0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'd5;
            3: return 32'hFFFF_FFFF;
            4: return 32'h8000_0000;
            5: return 32'd6;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int kind, imm;
        logic [2:0] f3;
        logic [31:0] p;
        rst = 1'b1; tick = 1'b0; instr_valid = 1'b0; instr = 32'h0; pc = 32'h0; rs1_val = 32'h0; rs2_val = 32'h0;
        m_in_redir = 1'b0; m_rem = 0; m_pc = 0; m_wdata = 0; m_cnt = 0; m_rd_addr = 0;
        step(1'b1, 1'b0, 1'b0, K_OTHER, 3'd0, 5'd0, 0, 32'h0, 32'h0, 32'h0);
        chk("reset_flush", 32'(flush), 32'd0);
        chk("reset_count", taken_count, 32'd0);
        step(1'b0, 1'b1, 1'b1, K_JAL, 3'd0, 5'd1, 16, 32'h100, 32'h0, 32'h0);
        chk("jal_rd_we", 32'(rd_we), 32'd1);
        chk("jal_rd_wdata", rd_wdata, 32'h104);
        chk("jal_target", pc_redirect, 32'h110);
        chk("jal_redirect", 32'(redirect), 32'd1);
        drain(FC);
        chk("jal_flush_window", 32'(flush), 32'd1);
        drain(1);
        chk("jal_flush_end", 32'(flush), 32'd0);
        step(1'b0, 1'b1, 1'b1, K_BR, 3'd0, 5'd0, -8, 32'h200, 32'd5, 32'd5);
        chk("beq_target", pc_redirect, 32'h1F8);
        drain(1);
        chk("beq_pulse", 32'(redirect), 32'd0);
        drain(FC);
        step(1'b0, 1'b1, 1'b1, K_BR, 3'd0, 5'd0, -8, 32'h200, 32'd5, 32'd6);
        chk("beq_nt", 32'(redirect | flush), 32'd0);
        step(1'b0, 1'b1, 1'b1, K_BR, 3'd4, 5'd0, 64, 32'h400, 32'hFFFF_FFFF, 32'd1);
        chk("blt_taken", 32'(redirect), 32'd1);
        drain(FC + 1);
        step(1'b0, 1'b1, 1'b1, K_BR, 3'd6, 5'd0, 64, 32'h400, 32'hFFFF_FFFF, 32'd1);
        chk("bltu_nt", 32'(redirect), 32'd0);
        step(1'b0, 1'b1, 1'b1, K_JALR, 3'd0, 5'd0, 0, 32'h500, 32'h1003, 32'h0);
        chk("jalr_mis", 32'(misalign), 32'd1);
        chk("jalr_mis_count", taken_count, 32'd3);
        step(1'b0, 1'b1, 1'b1, K_JALR, 3'd0, 5'd5, 3, 32'h600, 32'h1001, 32'h0);
        chk("jalr_target", pc_redirect, 32'h1004);
        chk("jalr_rd_we", 32'(rd_we), 32'd1);
        drain(FC + 1);
        step(1'b1, 1'b0, 1'b0, K_OTHER, 3'd0, 5'd0, 0, 32'h0, 32'h0, 32'h0);
        step(1'b0, 1'b1, 1'b1, K_BR, 3'd1, 5'd0, 32, 32'h300, 32'd1, 32'd2);
        step(1'b0, 1'b0, 1'b1, K_JAL, 3'd0, 5'd3, 8, 32'h304, 32'h0, 32'h0);
        step(1'b0, 1'b0, 1'b1, K_JAL, 3'd0, 5'd3, 8, 32'h304, 32'h0, 32'h0);
        chk("flush_hold_untick", 32'(flush), 32'd1);
        step(1'b0, 1'b1, 1'b1, K_JAL, 3'd0, 5'd3, 8, 32'h304, 32'h0, 32'h0);
        step(1'b0, 1'b0, 1'b1, K_JAL, 3'd0, 5'd3, 8, 32'h304, 32'h0, 32'h0);
        chk("flush_counts_ticks", 32'(flush), 32'd1);
        step(1'b0, 1'b1, 1'b1, K_JAL, 3'd0, 5'd3, 8, 32'h304, 32'h0, 32'h0);
        chk("flush_done", 32'(flush), 32'd0);
        chk("squash_count", taken_count, 32'd1);
        step(1'b0, 1'b1, 1'b1, K_BR, 3'd0, 5'd0, 16, 32'h700, 32'd9, 32'd9);
        drain(2);
        step(1'b1, 1'b1, 1'b0, K_OTHER, 3'd0, 5'd0, 0, 32'h0, 32'h0, 32'h0);
        chk("rst_mid_flush", 32'(flush), 32'd0);
        chk("rst_count", taken_count, 32'd0);
        step(1'b0, 1'b1, 1'b1, K_BR, 3'd5, 5'd0, 12, 32'h800, 32'd3, 32'd3);
        chk("post_rst_accept", pc_redirect, 32'h80C);
        step(1'b0, 1'b1, 1'b1, K_JAL, 3'd0, 5'd7, 16, 32'hFFFF_FFF0, 32'h0, 32'h0);
        drain(FC);
        step(1'b0, 1'b1, 1'b1, K_JAL, 3'd0, 5'd7, 16, 32'hFFFF_FFF0, 32'h0, 32'h0);
        chk("wrap_target", pc_redirect, 32'h0);
        for (int i = 0; i < 3000; i++) begin
            kind = int'($urandom_range(0, 3));
            f3 = 3'($urandom_range(0, 7));
            if (kind == K_JALR && $urandom_range(0, 3) != 0) f3 = 3'd0;
            imm = kind == K_JALR ? int'($urandom_range(0, 63)) - 32 : (int'($urandom_range(0, 127)) - 64) * 2;
            p = $urandom_range(0, 7) == 0 ? 32'hFFFF_FFF0 : $urandom() & 32'hFFFF_FFFC;
            step($urandom_range(0, 60) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7,
                 kind, f3, 5'($urandom_range(0, 31)), imm, p, pick(), pick());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
